// File: rtl/mem_store_unit.sv
// mem_store_unit: formats SB/SH/SW requests into lane-aligned SRAM writes and
// drains them in order from a small store buffer under an ack handshake.
`default_nettype none

module mem_store_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_size,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_device,
  output logic             st_ades,
  output logic [31:0]      st_badvaddr,
  output logic             dm_en,
  output logic [3:0]       dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic             dm_ack,
  output logic             sb_empty,
  output logic [CNT_W-1:0] sb_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ades_q, ades_d;
  logic [31:0]      badvaddr_q, badvaddr_d;

  logic [3:0]       we_mem_q   [DEPTH];
  logic [31:0]      addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];

  logic [7:0]       b0, b1, b2, b3;
  logic             misaligned;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             nonempty;
  logic [3:0]       fmt_we;
  logic [31:0]      fmt_data;

  assign b0 = st_data[7:0];
  assign b1 = st_data[15:8];
  assign b2 = st_data[23:16];
  assign b3 = st_data[31:24];

  assign nonempty  = (count_q != '0);
  assign st_ready  = !cpu_rst && (count_q != FULL_CNT);
  assign handshake = st_valid && st_ready;
  assign push      = handshake && !misaligned;
  assign pop       = dm_ack && nonempty;

  always_comb begin
    misaligned = 1'b0;
    case (st_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = st_addr[0];
      SZ_WORD: misaligned = (st_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane 3 ([31:24]) holds the lowest address: big-endian lane order, the inverse of the load path.
  always_comb begin
    fmt_we   = 4'b0000;
    fmt_data = 32'h0000_0000;
    case (st_size)
      SZ_BYTE: begin
        case (st_addr[1:0])
          2'b00:   begin fmt_we = 4'b1000; fmt_data = {b0, 8'h00, 8'h00, 8'h00}; end
          2'b01:   begin fmt_we = 4'b0100; fmt_data = {8'h00, b0, 8'h00, 8'h00}; end
          2'b10:   begin fmt_we = 4'b0010; fmt_data = {8'h00, 8'h00, b0, 8'h00}; end
          default: begin fmt_we = 4'b0001; fmt_data = {8'h00, 8'h00, 8'h00, b0}; end
        endcase
      end
      SZ_HALF: begin
        if (st_addr[1]) begin
          fmt_we   = 4'b0011;
          fmt_data = {8'h00, 8'h00, b0, b1};
        end else begin
          fmt_we   = 4'b1100;
          fmt_data = {b0, b1, 8'h00, 8'h00};
        end
      end
      SZ_WORD: begin
        fmt_we   = 4'b1111;
        fmt_data = st_device ? st_data : {b0, b1, b2, b3};
      end
      default: begin
        fmt_we   = 4'b0000;
        fmt_data = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ades_d     = 1'b0;
    badvaddr_d = badvaddr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (handshake && misaligned) begin
      ades_d     = 1'b1;
      badvaddr_d = st_addr;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ades_q     <= 1'b0;
      badvaddr_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ades_q     <= ades_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Entry storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      we_mem_q[wr_ptr_q]   <= fmt_we;
      addr_mem_q[wr_ptr_q] <= {st_addr[31:2], 2'b00};
      data_mem_q[wr_ptr_q] <= fmt_data;
    end
  end

  assign st_ades     = ades_q;
  assign st_badvaddr = badvaddr_q;
  assign sb_count    = count_q;
  assign sb_empty    = !nonempty;
  assign dm_en       = nonempty;
  assign dm_we       = nonempty ? we_mem_q[rd_ptr_q]   : 4'b0000;
  assign dm_addr     = nonempty ? addr_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign dm_wdata    = nonempty ? data_mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed and randomized stimulus for mem_store_unit,
// checked against a queue-based reference of the store buffer.
`default_nettype none

module tb_mem_store_unit;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst = 1'b1;
  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [1:0]       st_size = 2'b00;
  logic [31:0]      st_addr = 32'h0;
  logic [31:0]      st_data = 32'h0;
  logic             st_device = 1'b0;
  logic             st_ades;
  logic [31:0]      st_badvaddr;
  logic             dm_en;
  logic [3:0]       dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             dm_ack = 1'b0;
  logic             sb_empty;
  logic [CNT_W-1:0] sb_count;

  mem_store_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_device   (st_device),
    .st_ades     (st_ades),
    .st_badvaddr (st_badvaddr),
    .dm_en       (dm_en),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic        exp_ades = 1'b0;
  logic [31:0] exp_bad  = 32'h0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  // Memory byte at offset k lands in lane (3-k), lane L being bits [8L+7:8L].
  function automatic wr_t format(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] data, input logic dev);
    wr_t         w;
    int          off;
    logic [31:0] half_sw;
    logic [3:0]  two_lanes;
    off    = int'(addr % 4);
    w.addr = addr - (addr % 4);
    if (size == 2'd0) begin
      w.we   = 4'(1 << (3 - off));
      w.data = {24'h0, data[7:0]} << (8 * (3 - off));
    end else if (size == 2'd1) begin
      half_sw   = {16'h0, data[7:0], data[15:8]};
      two_lanes = 4'b0011;
      w.we      = two_lanes << (2 - off);
      w.data    = half_sw << (8 * (2 - off));
    end else begin
      w.we   = 4'b1111;
      w.data = dev ? data : {data[7:0], data[15:8], data[23:16], data[31:24]};
    end
    return w;
  endfunction

  task automatic check_state(input string tag);
    bit nonempty;
    nonempty = (exp_q.size() != 0);
    check({tag, ".dm_en"}, dm_en, nonempty);
    check({tag, ".dm_we"}, dm_we, nonempty ? exp_q[0].we : 4'b0);
    check({tag, ".dm_addr"}, dm_addr, nonempty ? exp_q[0].addr : 32'h0);
    check({tag, ".dm_wdata"}, dm_wdata, nonempty ? exp_q[0].data : 32'h0);
    check({tag, ".sb_count"}, sb_count, exp_q.size());
    check({tag, ".sb_empty"}, sb_empty, !nonempty);
    check({tag, ".st_ready"}, st_ready, !cpu_rst && exp_q.size() < DEPTH);
    check({tag, ".st_ades"}, st_ades, exp_ades);
    check({tag, ".st_badvaddr"}, st_badvaddr, exp_bad);
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks the result.
  task automatic cycle(input string tag, input logic v, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic dev, input logic ack);
    bit hs, pop;
    st_valid  = v;
    st_size   = size;
    st_addr   = addr;
    st_data   = data;
    st_device = dev;
    dm_ack    = ack;
    #1;
    hs       = v && (exp_q.size() < DEPTH);
    pop      = ack && (exp_q.size() != 0);
    exp_ades = 1'b0;
    if (hs && is_misaligned(size, addr)) begin
      exp_ades = 1'b1;
      exp_bad  = addr;
    end
    if (pop) void'(exp_q.pop_front());
    if (hs && !is_misaligned(size, addr)) exp_q.push_back(format(size, addr, data, dev));
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag, input logic ack);
    cycle(tag, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, ack);
  endtask

  initial begin
    // Reset values while reset is held
    @(negedge cpu_clk);
    check_state("reset");
    cpu_rst = 1'b0;
    #1;
    check_state("post_reset");

    // SW, memory byte order vs device order
    cycle("sw_mem", 1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344, 1'b0, 1'b0);
    check("sw_mem.wdata_const", dm_wdata, 32'h4433_2211);
    cycle("sw_dev_pop", 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle("sw_dev", 1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344, 1'b1, 1'b0);
    check("sw_dev.wdata_const", dm_wdata, 32'h1122_3344);
    idle("sw_dev_drain", 1'b1);

    // SB and SH lane placement
    cycle("sb", 1'b1, 2'd0, 32'h0000_0021, 32'h0000_00AB, 1'b0, 1'b0);
    check("sb.we_const", dm_we, 4'b0100);
    check("sb.wdata_const", dm_wdata, 32'h00AB_0000);
    cycle("sh", 1'b1, 2'd1, 32'h0000_0022, 32'h0000_BEEF, 1'b0, 1'b1);
    check("sh.we_const", dm_we, 4'b0011);
    check("sh.wdata_const", dm_wdata, 32'h0000_EFBE);
    idle("sh_drain", 1'b1);

    // Misaligned rejects
    cycle("ades_h", 1'b1, 2'd1, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cycle("ades_w", 1'b1, 2'd2, 32'h0000_0002, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cycle("ades_r", 1'b1, 2'd3, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle("ades_idle", 1'b0);

    // Full buffer, no bypass, FIFO order
    cycle("fill0", 1'b1, 2'd2, 32'h0000_0100, 32'hA0A0_A0A0, 1'b1, 1'b0);
    cycle("fill1", 1'b1, 2'd2, 32'h0000_0104, 32'hA1A1_A1A1, 1'b1, 1'b0);
    cycle("fill2", 1'b1, 2'd2, 32'h0000_0108, 32'hA2A2_A2A2, 1'b1, 1'b0);
    cycle("full_ack", 1'b1, 2'd2, 32'h0000_0108, 32'hA2A2_A2A2, 1'b1, 1'b1);
    cycle("third_in", 1'b1, 2'd2, 32'h0000_0108, 32'hA2A2_A2A2, 1'b1, 1'b0);
    idle("drain_a", 1'b1);
    idle("drain_b", 1'b1);

    // Reset mid-drain with two entries
    cycle("pre_rst0", 1'b1, 2'd0, 32'h0000_0200, 32'h0000_0055, 1'b0, 1'b0);
    cycle("pre_rst1", 1'b1, 2'd0, 32'h0000_0203, 32'h0000_0066, 1'b0, 1'b0);
    st_valid = 1'b0;
    cpu_rst  = 1'b1;
    #1;
    exp_q.delete();
    exp_ades = 1'b0;
    exp_bad  = 32'h0;
    check_state("in_rst");
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1;
    check_state("rst_release");
    idle("after_rst0", 1'b1);
    idle("after_rst1", 1'b1);

    // Streaming with continuous ack, wrapping the pointers
    for (int i = 0; i < 8; i++) begin
      cycle("stream", 1'b1, 2'd2, 32'h0000_0300 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b1);
      check("stream.count", sb_count, 1);
    end
    idle("stream_end", 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Store-side counterpart of the writeback load extractor. It turns a store request (SB/SH/SW) from the memory stage into a lane-aligned byte-write-enable and write-data word for the data SRAM port.
- Byte-lane mapping and endianness swap are the exact inverse of the load path. A word read back by the load path therefore returns the value that was stored.
- It holds committed stores in a small in-order store buffer and drains them to the data port under an ack handshake.
- It flags misaligned stores as an address-error (AdES) exception.

Parameters:
DEPTH, 2, store-buffer entries; power of two, >= 2
CNT_W, 2, width of sb_count; must satisfy 2^CNT_W > DEPTH

Ports:
cpu_clk  in  1  single clock, rising edge
cpu_rst  in  1  asynchronous, active-high reset
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept the request this cycle
st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
st_addr  in  32  byte address
st_data  in  32  rt register value, right-aligned
st_device  in  1  target is a device region (no endian swap)
st_ades  out  1  one-cycle pulse: misaligned or reserved store rejected
st_badvaddr  out  32  address of the last rejected store
dm_en  out  1  data-port write request
dm_we  out  4  byte write enables, bit3 = lane [31:24]
dm_addr  out  32  word address, low two bits zero
dm_wdata  out  32  lane-formatted write data
dm_ack  in  1  data port accepts the head entry this edge
sb_empty  out  1  buffer empty
sb_count  out  CNT_W  occupied entries

Behaviour:
- Reset (async, while cpu_rst=1):
  - Read/write pointers and count are cleared; sb_empty=1.
  - st_ready=0, st_ades=0, st_badvaddr=0.
  - dm_en=0, dm_we=0, dm_addr=0, dm_wdata=0.
  - Reset mid-drain discards all buffered stores; dm_en falls immediately, without waiting for an edge.
- Accept rule:
  - st_ready = !cpu_rst & (sb_count != DEPTH).
  - A request is taken when st_valid & st_ready at the rising edge.
  - There is no same-cycle bypass: when full, st_ready=0 even if dm_ack=1 in that cycle.
- Alignment check, performed at accept time:
  - Reject on: half with addr[0]=1; word with addr[1:0]!=00; st_size=11.
  - A rejected request is consumed (it counts as handshaken) but not enqueued.
  - Next cycle: st_ades=1 for exactly one cycle, and st_badvaddr<=st_addr. st_badvaddr holds until the next reject.
- Formatting, combinational at accept and stored in the entry (b0..b3 = st_data[7:0]..[31:24]; the word is listed MSB lane first):
  - Byte, off 00: we 1000, data {b0,0,0,0}.
  - Byte, off 01: we 0100, data {0,b0,0,0}.
  - Byte, off 10: we 0010, data {0,0,b0,0}.
  - Byte, off 11: we 0001, data {0,0,0,b0}.
  - Half, off 00: we 1100, data {b0,b1,0,0}.
  - Half, off 10: we 0011, data {0,0,b0,b1}.
  - Word, st_device=0: we 1111, data {b0,b1,b2,b3} (byte-reversed).
  - Word, st_device=1: we 1111, data st_data unchanged.
  - The device flag affects word stores only.
  - Unused lanes carry zero.
  - Entry address = {st_addr[31:2],2'b00}.
- Drain:
  - dm_en=1 whenever the buffer is non-empty; dm_we/dm_addr/dm_wdata come from the head entry.
  - Outputs are stable until dm_ack=1 is sampled at an edge; the head is then popped.
  - dm_ack while empty is ignored.
  - When empty: dm_we, dm_addr and dm_wdata are all 0.
- Latency: an accepted store is presented on dm_* at earliest the cycle after acceptance (registered path). Order is strictly FIFO.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Full: no push is allowed, and the entries are not corrupted.
- Empty: no pop is performed.

Test Plan:
1. Reset pulse cpu_rst=1 mid-drain with 2 entries -> dm_en=0 immediately; after release sb_empty=1, sb_count=0, st_ready=1, no further writes issued.
2. SW addr 0x00000010, data 0x11223344: with st_device=0 -> next cycle dm_en=1, dm_we=1111, dm_addr=0x10, dm_wdata=0x44332211. With st_device=1 -> dm_wdata=0x11223344.
3. SB data 0x000000AB to addr 0x..21 -> dm_we=0100, dm_wdata=0x00AB0000. SH data 0x0000BEEF to addr 0x..22 -> dm_we=0011, dm_wdata=0x0000EFBE. Both round-trip through the load extractor to 0xFFFFFFAB/0xFFFFBEEF (signed).
4. SH to 0x..01 and SW to 0x..02 -> st_ades pulses one cycle each; st_badvaddr=0x..01 then 0x..02; dm_en stays 0; sb_count stays 0.
5. dm_ack held 0, issue 3 stores back-to-back -> st_ready=0 after 2 accepts with sb_count=2. Raise dm_ack for one edge -> first store popped, st_ready=1, third store accepted next edge, order preserved.
6. dm_ack=1 continuously with a store every cycle -> one write per cycle, sb_count steady at 1, wrap-around over 8 stores with no loss or reorder.
